// File: rtl/mmio_test_device.sv
// Memory-mapped test-status responder: TOHOST pass/fail word, console byte port,
// a small signature buffer and a RUN-cycle watchdog, sitting beside data memory.
module mmio_test_device #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
    parameter logic [31:0] SIG_BASE       = 32'h0000_1100,
    parameter int          SIG_WORDS      = 8,
    parameter int          TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_code,
    output logic [31:0] cycles,
    output logic        char_valid,
    output logic [7:0]  char_data
);
    // state      | meaning
    // ST_RUN     | program running, stores accepted, cycles counting
    // ST_PASS    | program reported success (terminal)
    // ST_FAIL    | program reported failure, fail_code captured (terminal)
    // ST_TIMEOUT | watchdog expired before any report (terminal)
    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

    localparam int IDX_W = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  char_data_q, char_data_d;
    logic [31:0] sig_q [SIG_WORDS];
    logic [31:0] sig_d [SIG_WORDS];

    logic [31:0]      sig_off;
    logic [IDX_W-1:0] sig_idx;
    logic             tohost_sel, console_sel, sig_sel;
    logic             store, running;

    // Addresses below SIG_BASE wrap to a huge offset, so one compare bounds the window.
    assign sig_off     = req_addr - SIG_BASE;
    assign sig_idx     = sig_off[IDX_W+1:2];
    assign sig_sel     = (sig_off[31:2] < 30'(SIG_WORDS));
    assign tohost_sel  = (req_addr[31:2] == TOHOST_ADDR[31:2]);
    assign console_sel = (req_addr[31:2] == CONSOLE_ADDR[31:2]);

    assign hit     = req_valid & (tohost_sel | console_sel | sig_sel);
    assign store   = hit & req_we;
    assign running = (state_q == ST_RUN);

    always_comb begin
        rdata = '0;
        if (hit) begin
            if (tohost_sel) begin
                rdata = {fail_code_q, (state_q == ST_FAIL) | (state_q == ST_PASS)};
            end else if (console_sel) begin
                rdata = {24'b0, char_data_q};
            end else begin
                rdata = sig_q[sig_idx];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cycles_d     = cycles_q;
        fail_code_d  = fail_code_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        sig_d        = sig_q;
        if (running) begin
            if (cycles_q != 32'hFFFF_FFFF) begin
                cycles_d = cycles_q + 32'd1;
            end
            if (cycles_q == WDOG_LAST) begin
                state_d = ST_TIMEOUT;
            end
            // Written after the watchdog so a same-edge report overrides expiry.
            if (store && tohost_sel && (req_wstrb == 4'hF) && req_wdata[0]) begin
                if (req_wdata == 32'd1) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = req_wdata[31:1];
                end
            end
            if (store && console_sel && req_wstrb[0]) begin
                char_valid_d = 1'b1;
                char_data_d  = req_wdata[7:0];
            end
            if (store && sig_sel) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_wstrb[b]) begin
                        sig_d[sig_idx][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cycles_q     <= '0;
            fail_code_q  <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
            for (int i = 0; i < SIG_WORDS; i++) begin
                sig_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            fail_code_q  <= fail_code_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            sig_q        <= sig_d;
        end
    end

    assign done       = (state_q != ST_RUN);
    assign pass       = (state_q == ST_PASS);
    assign timeout    = (state_q == ST_TIMEOUT);
    assign fail_code  = fail_code_q;
    assign cycles     = cycles_q;
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;

endmodule

// File: tb/tb_mmio_test_device.sv
// Directed bench for mmio_test_device: a default-timeout instance (a) and a
// 16-cycle watchdog instance (b) share one request bus.
module tb_mmio_test_device;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    logic        hit_a, done_a, pass_a, timeout_a, char_valid_a;
    logic [31:0] rdata_a, cycles_a;
    logic [30:0] fail_code_a;
    logic [7:0]  char_data_a;
    logic        hit_b, done_b, pass_b, timeout_b, char_valid_b;
    logic [31:0] rdata_b, cycles_b;
    logic [30:0] fail_code_b;
    logic [7:0]  char_data_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_test_device dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .hit(hit_a), .rdata(rdata_a), .done(done_a), .pass(pass_a),
        .timeout(timeout_a), .fail_code(fail_code_a), .cycles(cycles_a),
        .char_valid(char_valid_a), .char_data(char_data_a)
    );

    mmio_test_device #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .hit(hit_b), .rdata(rdata_b), .done(done_b), .pass(pass_b),
        .timeout(timeout_b), .fail_code(fail_code_b), .cycles(cycles_b),
        .char_valid(char_valid_b), .char_data(char_data_b)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        drive_store(addr, data, strb);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic load(input logic [31:0] addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_wdata = '0;
        req_wstrb = '0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{"sig_w1",        1'b1, 32'h0000_1104, 1'b1, 32'hAABB_CC11};
        vecs[1]  = '{"sig_w1_unal",   1'b1, 32'h0000_1106, 1'b1, 32'hAABB_CC11};
        vecs[2]  = '{"sig_w0",        1'b1, 32'h0000_1100, 1'b1, 32'h0000_0000};
        vecs[3]  = '{"sig_w7",        1'b1, 32'h0000_111C, 1'b1, 32'h0000_0000};
        vecs[4]  = '{"sig_beyond",    1'b1, 32'h0000_1120, 1'b0, 32'h0000_0000};
        vecs[5]  = '{"below_sig",     1'b1, 32'h0000_10FC, 1'b0, 32'h0000_0000};
        vecs[6]  = '{"page_gap",      1'b1, 32'h0000_1008, 1'b0, 32'h0000_0000};
        vecs[7]  = '{"no_valid",      1'b0, 32'h0000_1104, 1'b0, 32'h0000_0000};
        vecs[8]  = '{"console_load",  1'b1, 32'h0000_1004, 1'b1, 32'h0000_0042};
        vecs[9]  = '{"tohost_run",    1'b1, 32'h0000_1000, 1'b1, 32'h0000_0000};
        vecs[10] = '{"alias_page",    1'b1, 32'h0000_2104, 1'b0, 32'h0000_0000};

        // Reset and idle
        do_reset();
        chk("reset_cycles", cycles_a, 32'd0);
        chk("reset_done", {31'b0, done_a}, 32'd0);
        idle(20);
        chk("idle_done", {31'b0, done_a}, 32'd0);
        chk("idle_pass", {31'b0, pass_a}, 32'd0);
        chk("idle_cycles", cycles_a, 32'd20);
        req_addr = 32'h0000_1000;
        #1;
        chk("idle_hit_novalid", {31'b0, hit_a}, 32'd0);
        bus_idle();

        // PASS report at cycle 5, then freeze
        do_reset();
        idle(5);
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        chk("pass_flag", {31'b0, pass_a}, 32'd1);
        chk("pass_done", {31'b0, done_a}, 32'd1);
        chk("pass_cycles", cycles_a, 32'd6);
        idle(3);
        chk("pass_cycles_frozen", cycles_a, 32'd6);
        store(32'h0000_1004, 32'h0000_0055, 4'hF);
        chk("frozen_char_valid", {31'b0, char_valid_a}, 32'd0);
        chk("frozen_char_data", {24'b0, char_data_a}, 32'd0);
        load(32'h0000_1000);
        chk("pass_load_hit", {31'b0, hit_a}, 32'd1);
        chk("pass_load_rdata", rdata_a, 32'd1);
        bus_idle();

        // Ignored reports, then FAIL report and terminal hold
        do_reset();
        store(32'h0000_1000, 32'h0000_0002, 4'hF);
        chk("even_ignored", {31'b0, done_a}, 32'd0);
        store(32'h0000_1000, 32'h0000_0001, 4'h7);
        chk("partial_ignored", {31'b0, done_a}, 32'd0);
        store(32'h0000_1000, 32'h0000_0007, 4'hF);
        chk("fail_done", {31'b0, done_a}, 32'd1);
        chk("fail_pass", {31'b0, pass_a}, 32'd0);
        chk("fail_code", {1'b0, fail_code_a}, 32'd3);
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        chk("fail_terminal_pass", {31'b0, pass_a}, 32'd0);
        chk("fail_terminal_code", {1'b0, fail_code_a}, 32'd3);
        load(32'h0000_1000);
        chk("fail_load_rdata", rdata_a, 32'd7);
        bus_idle();

        // Console back-to-back pulses
        do_reset();
        drive_store(32'h0000_1004, 32'h0000_0041, 4'h1);
        @(negedge clk);
        chk("char1_valid", {31'b0, char_valid_a}, 32'd1);
        chk("char1_data", {24'b0, char_data_a}, 32'h41);
        drive_store(32'h0000_1004, 32'h0000_0042, 4'h1);
        @(negedge clk);
        bus_idle();
        chk("char2_valid", {31'b0, char_valid_a}, 32'd1);
        chk("char2_data", {24'b0, char_data_a}, 32'h42);
        @(negedge clk);
        chk("char_pulse_end", {31'b0, char_valid_a}, 32'd0);
        store(32'h0000_1004, 32'h0000_0043, 4'h2);
        chk("char_lane1_valid", {31'b0, char_valid_a}, 32'd0);
        chk("char_lane1_data", {24'b0, char_data_a}, 32'h42);

        // Signature byte lanes and decode table
        store(32'h0000_1104, 32'hAABB_CCDD, 4'hF);
        store(32'h0000_1104, 32'h0000_0011, 4'h1);
        store(32'h0000_1120, 32'hFFFF_FFFF, 4'hF);
        store(32'h0000_1008, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].valid;
            req_we    = 1'b0;
            req_addr  = vecs[i].addr;
            #1;
            chk({vecs[i].name, "_hit"}, {31'b0, hit_a}, {31'b0, vecs[i].exp_hit});
            chk({vecs[i].name, "_rdata"}, rdata_a, vecs[i].exp_rdata);
        end
        bus_idle();
        @(negedge clk);
        chk("loads_no_effect", {31'b0, done_a}, 32'd0);

        // Watchdog expiry
        do_reset();
        load(32'h0000_1104);
        chk("sig_cleared", rdata_a, 32'd0);
        bus_idle();
        idle(15);
        chk("wdog_before", {31'b0, timeout_b}, 32'd0);
        idle(1);
        chk("wdog_timeout", {31'b0, timeout_b}, 32'd1);
        chk("wdog_done", {31'b0, done_b}, 32'd1);
        chk("wdog_cycles", cycles_b, 32'd16);
        idle(3);
        chk("wdog_cycles_frozen", cycles_b, 32'd16);

        // PASS on the expiry edge wins
        do_reset();
        idle(15);
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        chk("race_pass", {31'b0, pass_b}, 32'd1);
        chk("race_timeout", {31'b0, timeout_b}, 32'd0);

        // Asynchronous mid-run reset
        do_reset();
        idle(16);
        store(32'h0000_1004, 32'h0000_0041, 4'h1);
        store(32'h0000_1104, 32'hDEAD_BEEF, 4'hF);
        chk("pre_rst_timeout", {31'b0, timeout_b}, 32'd1);
        chk("pre_rst_char", {24'b0, char_data_a}, 32'h41);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_timeout", {31'b0, timeout_b}, 32'd0);
        chk("arst_done", {31'b0, done_b}, 32'd0);
        chk("arst_cycles", cycles_a, 32'd0);
        chk("arst_char", {24'b0, char_data_a}, 32'd0);
        load(32'h0000_1104);
        chk("arst_sig", rdata_a, 32'd0);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("restart_cycles", cycles_a, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
